// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the light-stick song sequencer and its pattern ROM.
package light_stick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SONG_MIN = 4'd1;
  localparam logic [3:0] SONG_MAX = 4'd9;

  typedef struct packed {
    logic       last;
    logic [3:0] dur;
    logic [7:0] pattern;
  } rom_word_t;

  // A zero duration field stands for the longest step, 16 beats.
  function automatic logic [4:0] dur_ticks(input logic [3:0] dur);
    return (dur == 4'd0) ? 5'd16 : {1'b0, dur};
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Selector-side inputs and light-stick outputs of the song sequencer.
interface song_sequencer_if;
  logic       tick;
  logic       restart;
  logic [3:0] song_no;
  logic [7:0] led;
  logic [3:0] step;
  logic       playing;
  logic       song_done;

  modport master (
    output tick, restart, song_no,
    input  led, step, playing, song_done
  );

  modport slave (
    input  tick, restart, song_no,
    output led, step, playing, song_done
  );
endinterface

// File: rtl/song_sequencer_rom.sv
// Fixed per-song pattern table, address {song, step}, one-cycle registered read.
module song_rom
  import light_stick_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] song,
  input  logic [3:0] step,
  output rom_word_t  data
);

  function automatic rom_word_t rom_init(input logic [7:0] addr);
    logic [3:0] s;
    logic [3:0] t;
    rom_word_t  w;
    s = addr[7:4];
    t = addr[3:0];
    w = '0;
    if (s == 4'd1 && t < 4'd4) begin
      w.pattern = 8'h01 << t;
      w.dur     = 4'd2;
      w.last    = (t == 4'd3);
    end else if (s == 4'd2 && t < 4'd4) begin
      case (t)
        4'd0:    w.pattern = 8'h81;
        4'd1:    w.pattern = 8'h42;
        4'd2:    w.pattern = 8'h24;
        default: w.pattern = 8'h18;
      endcase
      w.dur  = 4'd1;
      w.last = (t == 4'd3);
    end else if (s >= 4'd3 && s <= SONG_MAX && t < 4'd2) begin
      // Remaining songs: two-step nibble chase, beat count equal to the song number.
      w.pattern = (t == 4'd0) ? {s, 4'h0} : {4'h0, s};
      w.dur     = s;
      w.last    = (t == 4'd1);
    end
    return w;
  endfunction

  rom_word_t rom_table [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign rom_table[gi] = rom_init(8'(gi));
  end

  always_ff @(posedge clk) begin
    data <= rom_table[{song, step}];
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through the selected song's ROM patterns on beat ticks and drives the LEDs.
module song_sequencer
  import light_stick_pkg::*;
#(
  parameter int NUM_SONGS = 9,
  parameter int STEPS     = 16,
  parameter bit LOOP      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  song_sequencer_if.slave   bus
);

  logic       restart_meta_reg;
  logic       restart_s_reg;
  logic [3:0] song_q1_reg;
  logic [3:0] song_q2_reg;
  logic [3:0] song_s_reg;

  state_t     state_reg;
  logic [3:0] cur_song_reg;
  logic [3:0] step_reg;
  logic [4:0] dur_cnt_reg;
  logic       last_reg;
  logic [7:0] led_reg;
  logic       playing_reg;
  logic       song_done_reg;

  logic       song_valid;
  logic       hold;
  logic       song_change;
  logic       advance;
  logic [3:0] rom_song;
  logic [3:0] rom_step;
  rom_word_t  rom_q;

  // The second song stage only propagates once both stages agree, filtering glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      restart_meta_reg <= 1'b1;
      restart_s_reg    <= 1'b1;
      song_q1_reg      <= 4'd0;
      song_q2_reg      <= 4'd0;
      song_s_reg       <= 4'd0;
    end else begin
      restart_meta_reg <= bus.restart;
      restart_s_reg    <= restart_meta_reg;
      song_q1_reg      <= bus.song_no;
      song_q2_reg      <= song_q1_reg;
      if (song_q1_reg == song_q2_reg) begin
        song_s_reg <= song_q2_reg;
      end
    end
  end

  assign song_valid  = (song_s_reg >= SONG_MIN) && (song_s_reg <= 4'(NUM_SONGS));
  assign hold        = restart_s_reg || !song_valid;
  assign song_change = (state_reg != IDLE) && (song_s_reg != cur_song_reg);
  assign advance     = (state_reg == PLAY) && bus.tick && (dur_cnt_reg == 5'd1);

  // ROM address is the step about to be fetched so its word is ready during FETCH.
  always_comb begin
    rom_song = cur_song_reg;
    rom_step = step_reg;
    if (state_reg == IDLE || song_change) begin
      rom_song = song_s_reg;
      rom_step = 4'd0;
    end else if (advance) begin
      rom_step = last_reg ? 4'd0 : step_reg + 4'd1;
    end
  end

  song_rom u_rom (
    .clk  (clk),
    .song (rom_song),
    .step (rom_step),
    .data (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_song_reg  <= 4'd1;
      step_reg      <= 4'd0;
      dur_cnt_reg   <= 5'd0;
      last_reg      <= 1'b0;
      led_reg       <= 8'd0;
      playing_reg   <= 1'b0;
      song_done_reg <= 1'b0;
    end else begin
      song_done_reg <= 1'b0;
      if (hold) begin
        state_reg   <= IDLE;
        step_reg    <= 4'd0;
        led_reg     <= 8'd0;
        playing_reg <= 1'b0;
      end else if (state_reg == IDLE || song_change) begin
        state_reg    <= FETCH;
        cur_song_reg <= song_s_reg;
        step_reg     <= 4'd0;
        led_reg      <= 8'd0;
        playing_reg  <= 1'b1;
      end else begin
        case (state_reg)
          FETCH: begin
            state_reg   <= PLAY;
            led_reg     <= rom_q.pattern;
            dur_cnt_reg <= dur_ticks(rom_q.dur);
            last_reg    <= rom_q.last || (step_reg == 4'(STEPS - 1));
          end
          PLAY: begin
            if (advance) begin
              led_reg <= 8'd0;
              if (!last_reg) begin
                step_reg  <= step_reg + 4'd1;
                state_reg <= FETCH;
              end else if (LOOP) begin
                step_reg  <= 4'd0;
                state_reg <= FETCH;
              end else begin
                state_reg     <= DONE;
                playing_reg   <= 1'b0;
                song_done_reg <= 1'b1;
              end
            end else if (bus.tick) begin
              dur_cnt_reg <= dur_cnt_reg - 5'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.led       = led_reg;
  assign bus.step      = step_reg;
  assign bus.playing   = playing_reg;
  assign bus.song_done = song_done_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: one-shot and looping sequencers side by side on shared stimulus.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       restart;
  logic [3:0] song_no;
  logic       auto_tick;
  int         cyc_cnt = 0;
  int         checks  = 0;
  int         errors  = 0;

  song_sequencer_if bus0 ();
  song_sequencer_if bus1 ();

  assign bus0.tick    = tick;
  assign bus0.restart = restart;
  assign bus0.song_no = song_no;
  assign bus1.tick    = tick;
  assign bus1.restart = restart;
  assign bus1.song_no = song_no;

  song_sequencer #(.NUM_SONGS(9), .STEPS(16), .LOOP(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  song_sequencer #(.NUM_SONGS(9), .STEPS(16), .LOOP(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [7:0] led0;
    logic [3:0] step0;
    logic       play0;
    logic       done0;
    logic [7:0] led1;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic t, input logic [7:0] l0, input logic [3:0] s0,
                              input logic p0, input logic d0, input logic [7:0] l1);
    vec_t v;
    v.tick = t; v.led0 = l0; v.step0 = s0; v.play0 = p0; v.done0 = d0; v.led1 = l1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Inputs for the next edge are set 1 time unit after each edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    tick = auto_tick && (cyc_cnt % 4 == 0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_led"},     int'(bus0.led),       0);
    chk({name, "_step"},    int'(bus0.step),      0);
    chk({name, "_playing"}, int'(bus0.playing),   0);
    chk({name, "_done"},    int'(bus0.song_done), 0);
  endtask

  initial begin
    rst = 1'b1; restart = 1'b1; song_no = 4'd1; tick = 1'b0; auto_tick = 1'b0;

    // Song 1 from restart release: 4 steps of 2 beats, beats every 4 cycles.
    repeat (2) vec.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00));
    vec.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00));
    repeat (2) vec.push_back(mk(0, 8'h01, 0, 1, 0, 8'h01));
    vec.push_back(mk(1, 8'h01, 0, 1, 0, 8'h01));
    repeat (3) vec.push_back(mk(0, 8'h01, 0, 1, 0, 8'h01));
    vec.push_back(mk(1, 8'h00, 1, 1, 0, 8'h00));
    repeat (3) vec.push_back(mk(0, 8'h02, 1, 1, 0, 8'h02));
    vec.push_back(mk(1, 8'h02, 1, 1, 0, 8'h02));
    repeat (3) vec.push_back(mk(0, 8'h02, 1, 1, 0, 8'h02));
    vec.push_back(mk(1, 8'h00, 2, 1, 0, 8'h00));
    repeat (3) vec.push_back(mk(0, 8'h04, 2, 1, 0, 8'h04));
    vec.push_back(mk(1, 8'h04, 2, 1, 0, 8'h04));
    repeat (3) vec.push_back(mk(0, 8'h04, 2, 1, 0, 8'h04));
    vec.push_back(mk(1, 8'h00, 3, 1, 0, 8'h00));
    repeat (3) vec.push_back(mk(0, 8'h08, 3, 1, 0, 8'h08));
    vec.push_back(mk(1, 8'h08, 3, 1, 0, 8'h08));
    repeat (3) vec.push_back(mk(0, 8'h08, 3, 1, 0, 8'h08));
    vec.push_back(mk(1, 8'h00, 3, 0, 1, 8'h00));
    repeat (2) vec.push_back(mk(0, 8'h00, 3, 0, 0, 8'h01));

    repeat (3) clk_step();
    rst = 1'b0;
    repeat (20) clk_step();
    chk_idle("reset_idle");
    chk("reset_led1", int'(bus1.led), 0);
    $display("reset hold: led=%0h step=%0d playing=%0b", bus0.led, bus0.step, bus0.playing);

    restart = 1'b0;
    for (int i = 0; i < vec.size(); i++) begin
      tick = vec[i].tick;
      clk_step();
      $display("vec %0d tick=%0b led0=%0h step0=%0d play0=%0b done0=%0b led1=%0h",
               i, vec[i].tick, bus0.led, bus0.step, bus0.playing, bus0.song_done, bus1.led);
      chk($sformatf("vec%0d_led0", i),  int'(bus0.led),       int'(vec[i].led0));
      chk($sformatf("vec%0d_step0", i), int'(bus0.step),      int'(vec[i].step0));
      chk($sformatf("vec%0d_play0", i), int'(bus0.playing),   int'(vec[i].play0));
      chk($sformatf("vec%0d_done0", i), int'(bus0.song_done), int'(vec[i].done0));
      chk($sformatf("vec%0d_led1", i),  int'(bus1.led),       int'(vec[i].led1));
      chk($sformatf("vec%0d_done1", i), int'(bus1.song_done), 0);
    end
    tick = 1'b0;

    // Abort during step 2 with a coincident beat, then replay.
    restart = 1'b1;
    repeat (5) clk_step();
    chk_idle("park");
    restart = 1'b0;
    auto_tick = 1'b1;
    for (int n = 0; n < 200 && !(bus0.step == 4'd2 && bus0.led == 8'h04); n++) clk_step();
    chk("reach_step2", int'(bus0.led), 8'h04);
    restart = 1'b1;
    tick = 1'b1;
    repeat (3) clk_step();
    $display("abort: led=%0h step=%0d playing=%0b", bus0.led, bus0.step, bus0.playing);
    chk_idle("abort");
    restart = 1'b0;
    for (int n = 0; n < 20 && bus0.led == 8'h00; n++) clk_step();
    chk("replay_led", int'(bus0.led), 8'h01);
    chk("replay_step", int'(bus0.step), 0);

    // Song change mid-playback reloads song 2 from its first step.
    song_no = 4'd2;
    for (int n = 0; n < 6; n++) begin
      clk_step();
      if (bus0.led == 8'h81) break;
    end
    $display("song change: led=%0h step=%0d", bus0.led, bus0.step);
    chk("song2_led", int'(bus0.led), 8'h81);
    chk("song2_step", int'(bus0.step), 0);

    // Out-of-range songs park in IDLE even with restart released.
    song_no = 4'd0;
    repeat (8) clk_step();
    chk_idle("song0");
    song_no = 4'd10;
    repeat (8) clk_step();
    chk_idle("song10");
    chk("song10_playing1", int'(bus1.playing), 0);

    // Reset in the middle of PLAY.
    song_no = 4'd1;
    for (int n = 0; n < 20 && bus0.led == 8'h00; n++) clk_step();
    chk("pre_rst_led", int'(bus0.led), 8'h01);
    rst = 1'b1;
    clk_step();
    $display("mid-play reset: led=%0h step=%0d playing=%0b", bus0.led, bus0.step, bus0.playing);
    chk_idle("rst_mid_play");
    rst = 1'b0;
    auto_tick = 1'b0;
    clk_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
